alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the single-cycle datapath ALU. Accepts one op per
//  cycle over a valid/ready handshake, computes ADD/SUB/XOR/shift/rotate/lane-add/byte-load,
//  registers the result and holds a persistent {Z,V,N} flag register updated per opcode.
//  Sits between decode/operand read and writeback; downstream backpressure stalls it.
// PARAMETERS
//  WIDTH   16  datapath width; even, >= 8
//  LANE_W  4   PADDSB lane width; must divide WIDTH
//  SHAMT_W 4   shift/rotate amount bits taken from in_b[SHAMT_W-1:0]; 2**SHAMT_W <= WIDTH
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        reset, synchronous, active-low
//  in_valid   in   1        operands/opcode valid
//  in_ready   out  1        block can accept this cycle
//  in_a       in   WIDTH    operand 1
//  in_b       in   WIDTH    operand 2 / immediate (low WIDTH/2 bits for LLB/LHB)
//  in_op      in   4        opcode
//  flush      in   1        drop held result (out_valid<=0); flags untouched
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_result out  WIDTH    registered result
//  out_illeg  out  1        registered: held op was an unsupported opcode
//  flag       out  3        registered {Z,V,N}
// BEHAVIOUR
//  Reset (rst_n=0 at edge): out_valid=0, out_result=0, out_illeg=0, flag=3'b000. Reset wins
//   over everything, including an in-flight accept.
//  Handshake: in_ready = !out_valid | out_ready (combinational, one stage, no skid).
//   Accept = in_valid & in_ready. On accept: result/illeg/flags registered, out_valid=1.
//   Held result stable while out_valid & !out_ready. out_valid drops when out_ready and no
//   new accept. Latency 1 cycle; throughput 1 op/cycle under continuous out_ready.
//  flush: out_valid<=0 next edge; if flush & accept same cycle, accept wins (new op held).
//  Opcodes:
//   0000 ADD  a+b          0001 SUB  a-b (a + ~b + 1)
//   0010 XOR  a^b          0100 SLL  a << sh      0101 SRA  a >>> sh (sign fill)
//   0110 ROR  rotate right a by sh; sh=0 -> a
//   0111 PADDSB per-LANE_W lane signed add, each lane saturates to +max/-min independently
//   1010 LLB  {a[W-1:W/2], b[W/2-1:0]}   1011 LHB  {b[W/2-1:0], a[W/2-1:0]}
//   other: result 0, out_illeg=1, flags held.
//  ADD/SUB overflow: V = operand signs equal (after b inversion for SUB) and sum sign differs.
//  Flag update on accept only:
//   ADD/SUB: Z,V,N all written (N = sign of final result, Z = final result==0).
//   XOR/SLL/SRA/ROR: Z written; V,N held.
//   PADDSB/LLB/LHB/illegal: all flags held.
//  Flags change on accept even if previous result still being drained? No: accept requires
//   in_ready, so flags always describe the op currently in/last through out_result.
// CONFIGURATION
//  ALU_SAT_EN defined: ADD/SUB saturate on overflow to 0x7FFF..F (pos) / 0x800..0 (neg); V=1.
//  ALU_SAT_EN undefined: ADD/SUB wrap modulo 2**WIDTH; V still reports overflow.
//  PADDSB lane saturation is unconditional.
// TESTING (WIDTH=16, LANE_W=4, out_ready=1 unless stated)
//  ADD 0x7FFF+0x0001 -> SAT: 0x7FFF, flag=3'b010; no SAT: 0x8000, flag=3'b011.
//  SUB 0x1234-0x1234 -> 0x0000, flag=3'b100; then XOR 0x00F0^0x000F -> 0x00FF, flag=3'b000.
//  PADDSB 0x7878+0x1111 -> 0x7979, flag unchanged; LHB a=0x12AB b=0x00CD -> 0xCDAB.
//  Backpressure: issue 2 ops, out_ready=0 3 cycles -> in_ready=0, result 1 stable; 2nd
//   accepted the cycle out_ready=1, appears next edge; no op lost or duplicated.
//  Reset mid-stream: rst_n=0 while out_valid=1, flag=3'b100 -> next edge out_valid=0,
//   out_result=0, flag=000; in_ready=1 after release.
//  Illegal op 0x3 -> out_result=0, out_illeg=1, flag held; flush with held result -> out_valid=0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
// master drives operands and consumes results; slave is the ALU stage.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_illeg;
  logic [2:0]       flag;

  modport master (
    output in_valid, in_a, in_b, in_op, flush, out_ready,
    input  in_ready, out_valid, out_result, out_illeg, flag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, flush, out_ready,
    output in_ready, out_valid, out_result, out_illeg, flag
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - one-stage registered ALU with {Z,V,N} flags
// ALU_SAT_EN: when defined, ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe #(
  parameter int WIDTH   = 16,
  parameter int LANE_W  = 4,
  parameter int SHAMT_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int LANES = WIDTH / LANE_W;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_ROR  = 4'b0110;
  localparam logic [3:0] OP_PADD = 4'b0111;
  localparam logic [3:0] OP_LLB  = 4'b1010;
  localparam logic [3:0] OP_LHB  = 4'b1011;

  logic               valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               illeg_q;
  logic [2:0]         flag_q;
  logic [WIDTH-1:0]   res_d;
  logic               illeg_d;
  logic [2:0]         flag_d;
  logic               accept;

  logic [SHAMT_W-1:0] sh;
  logic               is_sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   arith;
  logic               ovf;
  logic [WIDTH-1:0]   ror;
  logic [WIDTH-1:0]   padd;
  logic [LANE_W:0]    lane_sum;

  assign bus.in_ready   = !valid_q | bus.out_ready;
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = res_q;
  assign bus.out_illeg  = illeg_q;
  assign bus.flag       = flag_q;

  // SUB shares the adder: a + ~b + 1, with overflow judged on the inverted operand.
  always_comb begin
    sh     = bus.in_b[SHAMT_W-1:0];
    is_sub = (bus.in_op == OP_SUB);
    b_eff  = is_sub ? ~bus.in_b : bus.in_b;
    sum    = bus.in_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    ovf    = (bus.in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
`ifdef ALU_SAT_EN
    if (ovf)
      arith = bus.in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      arith = sum;
`else
    arith = sum;
`endif
    ror = (bus.in_a >> sh) | (bus.in_a << (WIDTH - int'(sh)));
  end

  always_comb begin
    padd     = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = {bus.in_a[i*LANE_W+LANE_W-1], bus.in_a[i*LANE_W +: LANE_W]}
               + {bus.in_b[i*LANE_W+LANE_W-1], bus.in_b[i*LANE_W +: LANE_W]};
      if (lane_sum[LANE_W] != lane_sum[LANE_W-1])
        padd[i*LANE_W +: LANE_W] = lane_sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                    : {1'b0, {(LANE_W-1){1'b1}}};
      else
        padd[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
    end
  end

  always_comb begin
    res_d   = '0;
    illeg_d = 1'b0;
    flag_d  = flag_q;
    case (bus.in_op)
      OP_ADD, OP_SUB: begin
        res_d  = arith;
        flag_d = {arith == '0, ovf, arith[WIDTH-1]};
      end
      OP_XOR: begin
        res_d     = bus.in_a ^ bus.in_b;
        flag_d[2] = (res_d == '0);
      end
      OP_SLL: begin
        res_d     = bus.in_a << sh;
        flag_d[2] = (res_d == '0);
      end
      OP_SRA: begin
        res_d     = $signed(bus.in_a) >>> sh;
        flag_d[2] = (res_d == '0);
      end
      OP_ROR: begin
        res_d     = ror;
        flag_d[2] = (res_d == '0);
      end
      OP_PADD: res_d = padd;
      OP_LLB:  res_d = {bus.in_a[WIDTH-1:WIDTH/2], bus.in_b[WIDTH/2-1:0]};
      OP_LHB:  res_d = {bus.in_b[WIDTH/2-1:0], bus.in_a[WIDTH/2-1:0]};
      default: illeg_d = 1'b1;
    endcase
  end

  // Accept outranks flush so a same-cycle new op is never dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      illeg_q <= 1'b0;
      flag_q  <= 3'b000;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= res_d;
      illeg_q <= illeg_d;
      flag_q  <= flag_d;
    end else if (bus.out_ready || bus.flush) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and random checks of alu_pipe against an arithmetic model
module tb_alu_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W), .LANE_W(4), .SHAMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic        m_valid = 1'b0;
  logic [15:0] m_res   = 16'h0;
  logic        m_illeg = 1'b0;
  logic [2:0]  m_flag  = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] fin, output logic [15:0] res,
                        output logic il, output logic [2:0] fo);
    int sa, sb, s, sh, la, lb;
    logic v;
    fo  = fin;
    il  = 1'b0;
    res = 16'h0;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sh  = int'(b[3:0]);
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? sa + sb : sa - sb;
        v = (s > 32767) || (s < -32768);
`ifdef ALU_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        res = s[15:0];
        fo  = {res == 16'h0, v, res[15]};
      end
      4'd2: begin res = a ^ b; fo[2] = (res == 16'h0); end
      4'd4: begin res = 16'(int'(a) << sh); fo[2] = (res == 16'h0); end
      4'd5: begin res = 16'(sa >>> sh); fo[2] = (res == 16'h0); end
      4'd6: begin res = 16'((int'(a) >> sh) | (int'(a) << (16 - sh))); fo[2] = (res == 16'h0); end
      4'd7: begin
        for (int i = 0; i < 4; i++) begin
          la = int'($signed(a[4*i +: 4]));
          lb = int'($signed(b[4*i +: 4]));
          s  = la + lb;
          if (s > 7)  s = 7;
          if (s < -8) s = -8;
          res[4*i +: 4] = s[3:0];
        end
      end
      4'd10: res = {a[15:8], b[7:0]};
      4'd11: res = {b[7:0], a[7:0]};
      default: il = 1'b1;
    endcase
  endtask

  // One clock: drive inputs, check in_ready, predict the post-edge state, check it.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy, input logic fl);
    logic exp_rdy;
    logic [15:0] r;
    logic il;
    logic [2:0] f;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    exp_rdy = !m_valid | ordy;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (!rst_n) begin
      m_valid = 1'b0; m_res = 16'h0; m_illeg = 1'b0; m_flag = 3'b000;
    end else if (v && exp_rdy) begin
      ref_op(op, a, b, m_flag, r, il, f);
      m_valid = 1'b1; m_res = r; m_illeg = il; m_flag = f;
    end else if (ordy || fl) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_result", 32'(bus.out_result), 32'(m_res));
      chk("out_illeg", 32'(bus.out_illeg), 32'(m_illeg));
    end
    chk("flag", 32'(bus.flag), 32'(m_flag));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 4'h0; bus.in_a = 16'h0; bus.in_b = 16'h0;
    bus.out_ready = 1'b1; bus.flush = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("rst_result", 32'(bus.out_result), 32'h0);
    chk("rst_illeg", 32'(bus.out_illeg), 32'h0);
    rst_n = 1'b1;

    cycle(1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b1, 1'b0);
`ifdef ALU_SAT_EN
    chk("add_sat_res", 32'(bus.out_result), 32'h7FFF);
    chk("add_sat_flag", 32'(bus.flag), 32'h2);
`else
    chk("add_wrap_res", 32'(bus.out_result), 32'h8000);
    chk("add_wrap_flag", 32'(bus.flag), 32'h3);
`endif
    cycle(1'b1, 4'h1, 16'h1234, 16'h1234, 1'b1, 1'b0);
    chk("sub_zero_res", 32'(bus.out_result), 32'h0000);
    chk("sub_zero_flag", 32'(bus.flag), 32'h4);
    cycle(1'b1, 4'h2, 16'h00F0, 16'h000F, 1'b1, 1'b0);
    chk("xor_res", 32'(bus.out_result), 32'h00FF);
    chk("xor_flag", 32'(bus.flag), 32'h0);
    cycle(1'b1, 4'h7, 16'h7878, 16'h1111, 1'b1, 1'b0);
    chk("paddsb_res", 32'(bus.out_result), 32'h7979);
    cycle(1'b1, 4'hB, 16'h12AB, 16'h00CD, 1'b1, 1'b0);
    chk("lhb_res", 32'(bus.out_result), 32'hCDAB);
    cycle(1'b1, 4'h6, 16'h1234, 16'h0000, 1'b1, 1'b0);
    cycle(1'b1, 4'h6, 16'h1234, 16'h0004, 1'b1, 1'b0);
    cycle(1'b1, 4'h5, 16'h8000, 16'h000F, 1'b1, 1'b0);

    cycle(1'b1, 4'h3, 16'h5555, 16'hAAAA, 1'b1, 1'b0);
    chk("illeg_res", 32'(bus.out_result), 32'h0);
    chk("illeg_flag", 32'(bus.out_illeg), 32'h1);
    cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("flush_drop", 32'(bus.out_valid), 32'h0);
    cycle(1'b1, 4'h0, 16'h0003, 16'h0004, 1'b0, 1'b1);
    chk("flush_accept", 32'(bus.out_valid), 32'h1);

    cycle(1'b1, 4'h0, 16'h0001, 16'h0002, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h2, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_hold", 32'(bus.out_result), 32'h0003);
    end
    cycle(1'b1, 4'h2, 16'hF0F0, 16'h0FF0, 1'b1, 1'b0);
    chk("bp_second", 32'(bus.out_result), 32'hFF00);
    cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0);

    cycle(1'b1, 4'h1, 16'h0005, 16'h0005, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 4'h0, 16'h1111, 16'h2222, 1'b1, 1'b0);
    chk("midrst_result", 32'(bus.out_result), 32'h0);
    rst_n = 1'b1;
    cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            16'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
